// File: rtl/display_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | display_scan_ctrl: 4-digit common-anode 7-seg scan controller with         |
// | anti-ghost blanking, leading-zero suppression and frame-aligned loading.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module display_scan_ctrl #(
  parameter int DIV_COUNT    = 65000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [3:0]  an_out,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  localparam int              c_CW       = $clog2(DIV_COUNT + 1);
  localparam logic [c_CW-1:0] c_DIV      = c_CW'(DIV_COUNT);
  localparam logic [c_CW-1:0] c_BLK_LAST = c_CW'(BLANK_CYCLES - 1);

  typedef enum logic [0:0] {S_BLANK = 1'b0, S_SHOW = 1'b1} state_t;

  state_t          r_state;
  logic [c_CW-1:0] r_cnt;
  logic [c_CW-1:0] r_bcnt;
  logic [1:0]      r_digit;
  logic [15:0]     r_disp;
  logic [3:0]      r_dpr;
  logic [15:0]     r_pend;
  logic [3:0]      r_pdp;
  logic            r_full;

  state_t          w_nxt_state;
  logic [c_CW-1:0] w_nxt_bcnt;
  logic [1:0]      w_nxt_digit;
  logic [15:0]     w_nxt_disp;
  logic [3:0]      w_nxt_dpr;
  logic [3:0]      w_nib;
  logic [3:0]      w_lz;
  logic [3:0]      w_an;
  logic [6:0]      w_seg;
  logic            w_dp;
  logic            w_tick;
  logic            w_commit;
  logic            w_xfer;

  function automatic logic [6:0] f_seg(input logic [3:0] n);
    case (n)
      4'h0:    f_seg = 7'b1000000;
      4'h1:    f_seg = 7'b1111001;
      4'h2:    f_seg = 7'b0100100;
      4'h3:    f_seg = 7'b0110000;
      4'h4:    f_seg = 7'b0011001;
      4'h5:    f_seg = 7'b0010010;
      4'h6:    f_seg = 7'b0000010;
      4'h7:    f_seg = 7'b1111000;
      4'h8:    f_seg = 7'b0000000;
      4'h9:    f_seg = 7'b0010000;
      4'hA:    f_seg = 7'b0001000;
      4'hB:    f_seg = 7'b0000011;
      4'hC:    f_seg = 7'b1000110;
      4'hD:    f_seg = 7'b0100001;
      4'hE:    f_seg = 7'b0000110;
      default: f_seg = 7'b0001110;
    endcase
  endfunction

  assign w_tick     = (r_cnt == c_DIV);
  assign w_commit   = w_tick && (r_digit == 2'd3);
  assign load_ready = ~r_full & ~rst;
  assign w_xfer     = load_valid & load_ready;
  assign digit_idx  = r_digit;

  // Outputs are computed from next-state values so they land on the same edge.
  assign w_nxt_disp = (w_commit && r_full) ? r_pend : r_disp;
  assign w_nxt_dpr  = (w_commit && r_full) ? r_pdp  : r_dpr;
  assign w_nib      = w_nxt_disp[{w_nxt_digit, 2'b00} +: 4];

  assign w_lz[3] = blank_lz && (w_nxt_disp[15:12] == 4'h0);
  assign w_lz[2] = w_lz[3]  && (w_nxt_disp[11:8]  == 4'h0);
  assign w_lz[1] = w_lz[2]  && (w_nxt_disp[7:4]   == 4'h0);
  assign w_lz[0] = 1'b0;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_bcnt  = r_bcnt;
    w_nxt_digit = r_digit;
    if (w_tick) begin
      w_nxt_digit = r_digit + 2'd1;
      w_nxt_state = S_BLANK;
      w_nxt_bcnt  = '0;
    end else if (r_state == S_BLANK) begin
      if (r_bcnt == c_BLK_LAST) w_nxt_state = S_SHOW;
      else                      w_nxt_bcnt  = r_bcnt + 1'b1;
    end
  end

  always_comb begin
    w_an  = 4'hF;
    w_seg = 7'h7F;
    w_dp  = 1'b1;
    if (w_nxt_state == S_SHOW) begin
      // A suppressed digit still drives its decimal point, anode stays off.
      w_dp = ~w_nxt_dpr[w_nxt_digit];
      if (!w_lz[w_nxt_digit]) begin
        w_an  = ~(4'b0001 << w_nxt_digit);
        w_seg = f_seg(w_nib);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_cnt      <= '0;
      r_state    <= S_BLANK;
      r_bcnt     <= '0;
      r_digit    <= 2'd0;
      r_disp     <= 16'h0000;
      r_dpr      <= 4'h0;
      r_pend     <= 16'h0000;
      r_pdp      <= 4'h0;
      r_full     <= 1'b0;
      an_out     <= 4'hF;
      seg_out    <= 7'h7F;
      dp_out     <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      r_cnt      <= w_tick ? '0 : r_cnt + 1'b1;
      r_state    <= w_nxt_state;
      r_bcnt     <= w_nxt_bcnt;
      r_digit    <= w_nxt_digit;
      r_disp     <= w_nxt_disp;
      r_dpr      <= w_nxt_dpr;
      an_out     <= w_an;
      seg_out    <= w_seg;
      dp_out     <= w_dp;
      frame_done <= w_commit;
      if (w_xfer) begin
        r_pend <= value_in;
        r_pdp  <= dp_in;
        r_full <= 1'b1;
      end else if (w_commit) begin
        r_full <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_display_scan_ctrl: directed bench, DIV_COUNT=9 (10-cycle slots),        |
// | BLANK_CYCLES=2. Revision: 1.0                                              |
// +----------------------------------------------------------------------------+
module tb_display_scan_ctrl;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [3:0]  an_out;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  display_scan_ctrl #(.DIV_COUNT(9), .BLANK_CYCLES(2)) dut (
    .clk_in(clk_in), .rst(rst), .value_in(value_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .load_valid(load_valid), .load_ready(load_ready),
    .an_out(an_out), .seg_out(seg_out), .dp_out(dp_out),
    .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #40000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step(); step();
    nvec++; if (an_out !== 4'hF) begin nerr++; $display("FAIL rst_an: got %b exp 1111", an_out); end
    nvec++; if (seg_out !== 7'h7F) begin nerr++; $display("FAIL rst_seg: got %b exp 1111111", seg_out); end
    nvec++; if (dp_out !== 1'b1) begin nerr++; $display("FAIL rst_dp: got %b exp 1", dp_out); end
    nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL rst_fd: got %b exp 0", frame_done); end
    nvec++; if (digit_idx !== 2'd0) begin nerr++; $display("FAIL rst_idx: got %0d exp 0", digit_idx); end
    nvec++; if (load_ready !== 1'b0) begin nerr++; $display("FAIL rst_rdy_hi: got %b exp 0", load_ready); end
    rst = 1'b0;
    cyc = 0;
    #1;
    nvec++; if (load_ready !== 1'b1) begin nerr++; $display("FAIL rst_rdy_lo: got %b exp 1", load_ready); end
  endtask

  task automatic test_idle();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int ph, dig;
    for (int c = 0; c <= 40; c++) begin
      wait_to(c);
      ph  = c % 10;
      dig = (c / 10) % 4;
      exp_an  = (ph < 2) ? 4'hF : ~(4'b0001 << dig);
      exp_seg = (ph < 2) ? 7'h7F : 7'b1000000;
      nvec++; if (an_out !== exp_an) begin nerr++; $display("FAIL idle_an c=%0d: got %b exp %b", c, an_out, exp_an); end
      nvec++; if (seg_out !== exp_seg) begin nerr++; $display("FAIL idle_seg c=%0d: got %b exp %b", c, seg_out, exp_seg); end
      nvec++; if (digit_idx !== 2'(dig)) begin nerr++; $display("FAIL idle_idx c=%0d: got %0d exp %0d", c, digit_idx, dig); end
      nvec++; if (frame_done !== (c == 40)) begin nerr++; $display("FAIL idle_fd c=%0d: got %b exp %b", c, frame_done, (c == 40)); end
    end
  endtask

  task automatic test_load();
    wait_to(45);
    nvec++; if (load_ready !== 1'b1) begin nerr++; $display("FAIL load_rdy0: got %b exp 1", load_ready); end
    value_in = 16'h12AF; dp_in = 4'b0001; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    nvec++; if (load_ready !== 1'b0) begin nerr++; $display("FAIL load_rdy_drop: got %b exp 0", load_ready); end
    nvec++; if (seg_out !== 7'b1000000 || dp_out !== 1'b1) begin nerr++; $display("FAIL load_early: got %b/%b exp 1000000/1", seg_out, dp_out); end
    wait_to(75);
    nvec++; if (an_out !== 4'b0111 || seg_out !== 7'b1000000) begin nerr++; $display("FAIL load_d3_old: got %b/%b exp 0111/1000000", an_out, seg_out); end
    wait_to(79);
    nvec++; if (frame_done !== 1'b0 || load_ready !== 1'b0) begin nerr++; $display("FAIL load_pre: got fd=%b rdy=%b exp 0/0", frame_done, load_ready); end
    wait_to(80);
    nvec++; if (frame_done !== 1'b1) begin nerr++; $display("FAIL load_fd: got %b exp 1", frame_done); end
    wait_to(81);
    nvec++; if (load_ready !== 1'b1) begin nerr++; $display("FAIL load_rdy_back: got %b exp 1", load_ready); end
    wait_to(85);
    nvec++; if (an_out !== 4'b1110 || seg_out !== 7'b0001110 || dp_out !== 1'b0) begin nerr++; $display("FAIL load_d0: got %b/%b/%b exp 1110/0001110/0", an_out, seg_out, dp_out); end
    wait_to(95);
    nvec++; if (an_out !== 4'b1101 || seg_out !== 7'b0001000 || dp_out !== 1'b1) begin nerr++; $display("FAIL load_d1: got %b/%b/%b exp 1101/0001000/1", an_out, seg_out, dp_out); end
    wait_to(105);
    nvec++; if (an_out !== 4'b1011 || seg_out !== 7'b0100100) begin nerr++; $display("FAIL load_d2: got %b/%b exp 1011/0100100", an_out, seg_out); end
    wait_to(115);
    nvec++; if (an_out !== 4'b0111 || seg_out !== 7'b1111001) begin nerr++; $display("FAIL load_d3: got %b/%b exp 0111/1111001", an_out, seg_out); end
  endtask

  task automatic test_back_to_back();
    wait_to(125);
    nvec++; if (load_ready !== 1'b1) begin nerr++; $display("FAIL b2b_rdy0: got %b exp 1", load_ready); end
    value_in = 16'h3456; dp_in = 4'h0; load_valid = 1'b1;
    step();
    value_in = 16'h0789;
    for (int c = 126; c < 160; c++) begin
      wait_to(c);
      nvec++; if (load_ready !== 1'b0) begin nerr++; $display("FAIL b2b_hold c=%0d: got %b exp 0", c, load_ready); end
    end
    wait_to(160);
    nvec++; if (frame_done !== 1'b1 || load_ready !== 1'b1) begin nerr++; $display("FAIL b2b_commit: got fd=%b rdy=%b exp 1/1", frame_done, load_ready); end
    step();
    load_valid = 1'b0;
    nvec++; if (load_ready !== 1'b0) begin nerr++; $display("FAIL b2b_capt: got %b exp 0", load_ready); end
    wait_to(165);
    nvec++; if (seg_out !== 7'b0000010) begin nerr++; $display("FAIL b2b_first: got %b exp 0000010", seg_out); end
    wait_to(205);
    nvec++; if (seg_out !== 7'b0010000) begin nerr++; $display("FAIL b2b_d0: got %b exp 0010000", seg_out); end
    wait_to(215);
    nvec++; if (seg_out !== 7'b0000000) begin nerr++; $display("FAIL b2b_d1: got %b exp 0000000", seg_out); end
    wait_to(225);
    nvec++; if (seg_out !== 7'b1111000) begin nerr++; $display("FAIL b2b_d2: got %b exp 1111000", seg_out); end
    wait_to(235);
    nvec++; if (an_out !== 4'b0111 || seg_out !== 7'b1000000) begin nerr++; $display("FAIL b2b_d3: got %b/%b exp 0111/1000000", an_out, seg_out); end
  endtask

  task automatic test_lz();
    blank_lz = 1'b1;
    wait_to(245);
    value_in = 16'h0008; dp_in = 4'b0010; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int c = 280; c < 320; c++) begin
      wait_to(c);
      if (c == 285) begin value_in = 16'h0000; dp_in = 4'h0; load_valid = 1'b1; end
      if (c == 286) load_valid = 1'b0;
      nvec++; if (an_out[3:1] !== 3'b111) begin nerr++; $display("FAIL lz_an c=%0d: got %b exp 111x", c, an_out); end
      if (c == 285) begin
        nvec++; if (an_out !== 4'b1110 || seg_out !== 7'b0000000 || dp_out !== 1'b1) begin nerr++; $display("FAIL lz_d0: got %b/%b/%b exp 1110/0000000/1", an_out, seg_out, dp_out); end
      end
      if (c == 295) begin
        nvec++; if (seg_out !== 7'h7F || dp_out !== 1'b0) begin nerr++; $display("FAIL lz_dp1: got %b/%b exp 1111111/0", seg_out, dp_out); end
      end
    end
    wait_to(325);
    nvec++; if (an_out !== 4'b1110 || seg_out !== 7'b1000000) begin nerr++; $display("FAIL lz0_d0: got %b/%b exp 1110/1000000", an_out, seg_out); end
    for (int c = 335; c <= 355; c += 10) begin
      wait_to(c);
      nvec++; if (an_out !== 4'hF || seg_out !== 7'h7F) begin nerr++; $display("FAIL lz0_hi c=%0d: got %b/%b exp 1111/1111111", c, an_out, seg_out); end
    end
  endtask

  task automatic test_commit_edge();
    blank_lz = 1'b0;
    wait_to(399);
    nvec++; if (load_ready !== 1'b1 || digit_idx !== 2'd3) begin nerr++; $display("FAIL ce_pre: got rdy=%b idx=%0d exp 1/3", load_ready, digit_idx); end
    value_in = 16'h4321; dp_in = 4'h0; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    nvec++; if (frame_done !== 1'b1 || load_ready !== 1'b0) begin nerr++; $display("FAIL ce_edge: got fd=%b rdy=%b exp 1/0", frame_done, load_ready); end
    wait_to(405);
    nvec++; if (an_out !== 4'b1110 || seg_out !== 7'b1000000) begin nerr++; $display("FAIL ce_held: got %b/%b exp 1110/1000000", an_out, seg_out); end
    wait_to(440);
    nvec++; if (frame_done !== 1'b1 || load_ready !== 1'b1) begin nerr++; $display("FAIL ce_commit: got fd=%b rdy=%b exp 1/1", frame_done, load_ready); end
    wait_to(445);
    nvec++; if (seg_out !== 7'b1111001) begin nerr++; $display("FAIL ce_d0: got %b exp 1111001", seg_out); end
    wait_to(455);
    nvec++; if (an_out !== 4'b1101 || seg_out !== 7'b0100100) begin nerr++; $display("FAIL ce_d1: got %b/%b exp 1101/0100100", an_out, seg_out); end
  endtask

  task automatic test_reset_mid();
    wait_to(461);
    value_in = 16'hBEEF; dp_in = 4'hF; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    nvec++; if (load_ready !== 1'b0) begin nerr++; $display("FAIL rm_full: got %b exp 0", load_ready); end
    wait_to(465);
    nvec++; if (an_out !== 4'b1011 || digit_idx !== 2'd2) begin nerr++; $display("FAIL rm_pre: got %b/%0d exp 1011/2", an_out, digit_idx); end
    rst = 1'b1;
    step();
    nvec++; if (an_out !== 4'hF || digit_idx !== 2'd0 || seg_out !== 7'h7F) begin nerr++; $display("FAIL rm_rst: got %b/%0d/%b exp 1111/0/1111111", an_out, digit_idx, seg_out); end
    rst = 1'b0;
    cyc = 0;
    #1;
    nvec++; if (load_ready !== 1'b1) begin nerr++; $display("FAIL rm_rdy: got %b exp 1", load_ready); end
    wait_to(5);
    nvec++; if (an_out !== 4'b1110 || seg_out !== 7'b1000000 || dp_out !== 1'b1) begin nerr++; $display("FAIL rm_d0: got %b/%b/%b exp 1110/1000000/1", an_out, seg_out, dp_out); end
    wait_to(40);
    nvec++; if (frame_done !== 1'b1) begin nerr++; $display("FAIL rm_fd: got %b exp 1", frame_done); end
    wait_to(45);
    nvec++; if (seg_out !== 7'b1000000 || dp_out !== 1'b1) begin nerr++; $display("FAIL rm_nopend: got %b/%b exp 1000000/1", seg_out, dp_out); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load();
    test_back_to_back();
    test_lz();
    test_commit_edge();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
